// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage operand/op fields in, pipeline control, forwarding selects and MDU status out.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned AW = 5
);
  logic          rs1use_ID;
  logic          rs2use_ID;
  logic [AW-1:0] rs1_ID;
  logic [AW-1:0] rs2_ID;
  logic [AW-1:0] rd_ID;
  logic [2:0]    optype_ID;
  logic          Branch_ID;
  logic          cmu_stall;

  logic          PC_EN_IF;
  logic          reg_FD_EN;
  logic          reg_FD_stall;
  logic          reg_FD_flush;
  logic          reg_DE_EN;
  logic          reg_DE_flush;
  logic          reg_EM_EN;
  logic          reg_EM_flush;
  logic          reg_MW_EN;
  logic [2:0]    forward_ctrl_A;
  logic [2:0]    forward_ctrl_B;
  logic          forward_ctrl_ls;
  logic          mdu_issue;
  logic          mdu_wb_EN;
  logic [AW-1:0] mdu_rd;
  logic          mdu_busy;

  modport master (
    output rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, optype_ID, Branch_ID, cmu_stall,
    input  PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush,
           reg_EM_EN, reg_EM_flush, reg_MW_EN, forward_ctrl_A, forward_ctrl_B,
           forward_ctrl_ls, mdu_issue, mdu_wb_EN, mdu_rd, mdu_busy
  );

  modport slave (
    input  rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, optype_ID, Branch_ID, cmu_stall,
    output PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush,
           reg_EM_EN, reg_EM_flush, reg_MW_EN, forward_ctrl_A, forward_ctrl_B,
           forward_ctrl_ls, mdu_issue, mdu_wb_EN, mdu_rd, mdu_busy
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller for the 5-stage core with a pending-write scoreboard for one MDU.
// Control outputs are combinational from tracked EXE/MEM/MDU state and the ID-stage fields.
module hazard_scoreboard_unit #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter bit          FWD_EN  = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int unsigned OPW = 3;
  localparam int unsigned CW  = 4;

  localparam logic [OPW-1:0] OP_NONE   = OPW'(0);
  localparam logic [OPW-1:0] OP_ALU    = OPW'(1);
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(2);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(3);
  localparam logic [OPW-1:0] OP_MULDIV = OPW'(4);

  localparam logic [2:0] SEL_RF       = 3'd0;
  localparam logic [2:0] SEL_EXE_ALU  = 3'd1;
  localparam logic [2:0] SEL_MEM_ALU  = 3'd2;
  localparam logic [2:0] SEL_MEM_LOAD = 3'd3;
  localparam logic [2:0] SEL_MDU      = 3'd4;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_WB   = 2'd2
  } mdu_state_e;

  logic [OPW-1:0] exe_op, mem_op;
  logic [AW-1:0]  exe_rd, exe_rs2, mem_rd;
  mdu_state_e     state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [AW-1:0]  busy_rd, busy_rd_nxt;

  logic rs1_live, rs2_live;
  logic id_writes, id_muldiv, id_store;
  logic mdu_active, mdu_wb;
  logic mdu_raw, mdu_waw;
  logic load_stall, raw_stall, mdu_stall, stall;
  logic issue;

  // Youngest producer wins; the MDU port only counts in a writing WB cycle.
  function automatic logic [2:0] fwd_sel(
    input logic           live,
    input logic [AW-1:0]  rs,
    input logic [OPW-1:0] e_op,
    input logic [AW-1:0]  e_rd,
    input logic [OPW-1:0] m_op,
    input logic [AW-1:0]  m_rd,
    input logic           wb,
    input logic [AW-1:0]  w_rd
  );
    logic [2:0] sel;
    sel = SEL_RF;
    if (live) begin
      if (e_op == OP_ALU && e_rd == rs)       sel = SEL_EXE_ALU;
      else if (m_op == OP_ALU && m_rd == rs)  sel = SEL_MEM_ALU;
      else if (m_op == OP_LOAD && m_rd == rs) sel = SEL_MEM_LOAD;
      else if (wb && w_rd == rs)              sel = SEL_MDU;
    end
    return sel;
  endfunction

  assign rs1_live   = hz.rs1use_ID && (hz.rs1_ID != '0);
  assign rs2_live   = hz.rs2use_ID && (hz.rs2_ID != '0);
  assign id_muldiv  = (hz.optype_ID == OP_MULDIV);
  assign id_store   = (hz.optype_ID == OP_STORE);
  assign id_writes  = (hz.optype_ID == OP_ALU) || (hz.optype_ID == OP_LOAD) || id_muldiv;

  assign mdu_active = (state != MDU_IDLE);
  assign mdu_wb     = (state == MDU_WB) && !hz.cmu_stall;

  assign load_stall = FWD_EN && (exe_op == OP_LOAD) &&
                      ((rs1_live && exe_rd == hz.rs1_ID) ||
                       (rs2_live && exe_rd == hz.rs2_ID && !id_store));

  assign raw_stall  = !FWD_EN &&
                      (((exe_op != OP_NONE) &&
                        ((rs1_live && exe_rd == hz.rs1_ID) || (rs2_live && exe_rd == hz.rs2_ID))) ||
                       ((mem_op != OP_NONE) &&
                        ((rs1_live && mem_rd == hz.rs1_ID) || (rs2_live && mem_rd == hz.rs2_ID))));

  // In WB the result is on the bypass, so a RAW only stalls without forwarding.
  assign mdu_raw    = ((rs1_live && hz.rs1_ID == busy_rd) || (rs2_live && hz.rs2_ID == busy_rd)) &&
                      ((state == MDU_BUSY) || !FWD_EN);
  assign mdu_waw    = id_writes && (busy_rd != '0) && (hz.rd_ID == busy_rd);
  assign mdu_stall  = mdu_active && (mdu_raw || mdu_waw || id_muldiv);

  assign stall      = load_stall || raw_stall || mdu_stall;
  assign issue      = id_muldiv && !stall && !hz.cmu_stall && !hz.Branch_ID;

  assign hz.PC_EN_IF        = !stall && !hz.cmu_stall;
  assign hz.reg_FD_EN       = !hz.cmu_stall;
  assign hz.reg_FD_stall    = stall;
  assign hz.reg_FD_flush    = hz.Branch_ID && !stall;
  assign hz.reg_DE_EN       = !hz.cmu_stall;
  assign hz.reg_DE_flush    = stall;
  assign hz.reg_EM_EN       = !hz.cmu_stall;
  assign hz.reg_EM_flush    = 1'b0;
  assign hz.reg_MW_EN       = !hz.cmu_stall;
  assign hz.forward_ctrl_A  = FWD_EN ? fwd_sel(rs1_live, hz.rs1_ID, exe_op, exe_rd, mem_op, mem_rd,
                                               mdu_wb, busy_rd) : SEL_RF;
  assign hz.forward_ctrl_B  = FWD_EN ? fwd_sel(rs2_live, hz.rs2_ID, exe_op, exe_rd, mem_op, mem_rd,
                                               mdu_wb, busy_rd) : SEL_RF;
  assign hz.forward_ctrl_ls = FWD_EN && (exe_op == OP_STORE) && (mem_op == OP_LOAD) &&
                              (mem_rd != '0) && (exe_rs2 == mem_rd);
  assign hz.mdu_issue       = issue;
  assign hz.mdu_wb_EN       = mdu_wb;
  assign hz.mdu_rd          = busy_rd;
  assign hz.mdu_busy        = mdu_active;

  // EXE/MEM shadow of the datapath; MULDIV leaves through the MDU, not the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exe_op  <= OP_NONE;
      exe_rd  <= '0;
      exe_rs2 <= '0;
      mem_op  <= OP_NONE;
      mem_rd  <= '0;
    end else if (!hz.cmu_stall) begin
      exe_op  <= (stall || id_muldiv) ? OP_NONE : hz.optype_ID;
      exe_rd  <= hz.rd_ID;
      exe_rs2 <= hz.rs2_ID;
      mem_op  <= exe_op;
      mem_rd  <= exe_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MDU_IDLE;
      cnt     <= '0;
      busy_rd <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy_rd <= busy_rd_nxt;
    end
  end

  // MDU scoreboard: counts down the remaining latency, frozen by cmu_stall.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_rd_nxt = busy_rd;
    unique case (state)
      MDU_IDLE: begin
        if (issue) begin
          state_nxt   = MDU_BUSY;
          cnt_nxt     = CW'(MDU_LAT - 1);
          busy_rd_nxt = hz.rd_ID;
        end
      end
      MDU_BUSY: begin
        if (!hz.cmu_stall) begin
          if (cnt == CW'(1)) begin
            state_nxt = MDU_WB;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      MDU_WB: begin
        if (!hz.cmu_stall) state_nxt = MDU_IDLE;
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end
endmodule
